// File: rtl/alu_cmd_sequencer.sv
// Command sequencer for an external LEGv8 ALU: encodes ALUOp/opcode into ALUControl,
// drives registered operands, and returns the captured result over a valid/ready channel.
module alu_cmd_sequencer #(
    parameter int N     = 64,
    parameter int CNT_W = 16
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_cmd_valid,
    output logic             o_cmd_ready,
    input  logic [1:0]       i_cmd_aluop,
    input  logic [10:0]      i_cmd_opcode,
    input  logic [N-1:0]     i_cmd_a,
    input  logic [N-1:0]     i_cmd_b,
    output logic [N-1:0]     o_alu_a,
    output logic [N-1:0]     o_alu_b,
    output logic [3:0]       o_alu_ctrl,
    input  logic [N-1:0]     i_alu_result,
    input  logic             i_alu_zero,
    output logic             o_rsp_valid,
    input  logic             i_rsp_ready,
    output logic [N-1:0]     o_rsp_result,
    output logic             o_rsp_zero,
    output logic             o_rsp_err,
    output logic [CNT_W-1:0] o_op_count
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_ERR  = 2'd2,
        S_RESP = 2'd3
    } state_t;

    state_t            r_state;
    state_t            w_state_next;
    logic              r_phase;
    logic [N-1:0]      r_alu_a;
    logic [N-1:0]      r_alu_b;
    logic [3:0]        r_alu_ctrl;
    logic [N-1:0]      r_rsp_result;
    logic              r_rsp_zero;
    logic              r_rsp_err;
    logic [CNT_W-1:0]  r_op_count;
    logic [3:0]        w_code;
    logic              w_illegal;
    logic              w_accept;
    logic              w_busy;

    always_comb begin
        w_code    = 4'b0000;
        w_illegal = 1'b0;
        case (i_cmd_aluop)
            2'b00: w_code = 4'b0010;
            2'b01: w_code = 4'b0111;
            2'b10: begin
                case (i_cmd_opcode)
                    11'b10001011000: w_code = 4'b0010;
                    11'b11001011000: w_code = 4'b0110;
                    11'b10001010000: w_code = 4'b0000;
                    11'b10101010000: w_code = 4'b0001;
                    default:         w_illegal = 1'b1;
                endcase
            end
            default: w_illegal = 1'b1;
        endcase
    end

    // EXEC/ERR last two cycles: one for the ALU to settle on the new operands, one to capture.
    always_comb begin
        w_state_next = r_state;
        w_accept     = 1'b0;
        w_busy       = (r_state == S_EXEC) || (r_state == S_ERR);
        case (r_state)
            S_IDLE: begin
                if (i_cmd_valid) begin
                    w_accept     = 1'b1;
                    w_state_next = w_illegal ? S_ERR : S_EXEC;
                end
            end
            S_EXEC, S_ERR: begin
                if (r_phase) w_state_next = S_RESP;
            end
            S_RESP: begin
                if (i_rsp_ready) w_state_next = S_IDLE;
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state      <= S_IDLE;
            r_phase      <= 1'b0;
            r_alu_a      <= '0;
            r_alu_b      <= '0;
            r_alu_ctrl   <= 4'b0000;
            r_rsp_result <= '0;
            r_rsp_zero   <= 1'b0;
            r_rsp_err    <= 1'b0;
            r_op_count   <= '0;
        end else begin
            r_state <= w_state_next;
            r_phase <= w_busy ? ~r_phase : 1'b0;
            if (w_accept) begin
                r_alu_a    <= i_cmd_a;
                r_alu_b    <= i_cmd_b;
                r_alu_ctrl <= w_illegal ? 4'b0000 : w_code;
            end
            if (r_state == S_EXEC && r_phase) begin
                r_rsp_result <= i_alu_result;
                r_rsp_zero   <= i_alu_zero;
                r_rsp_err    <= 1'b0;
            end
            if (r_state == S_ERR && r_phase) begin
                r_rsp_result <= '0;
                r_rsp_zero   <= 1'b0;
                r_rsp_err    <= 1'b1;
            end
            if (r_state == S_RESP && i_rsp_ready) begin
                r_op_count <= r_op_count + CNT_W'(1);
            end
        end
    end

    assign o_cmd_ready  = (r_state == S_IDLE);
    assign o_rsp_valid  = (r_state == S_RESP);
    assign o_alu_a      = r_alu_a;
    assign o_alu_b      = r_alu_b;
    assign o_alu_ctrl   = r_alu_ctrl;
    assign o_rsp_result = r_rsp_result;
    assign o_rsp_zero   = r_rsp_zero;
    assign o_rsp_err    = r_rsp_err;
    assign o_op_count   = r_op_count;

endmodule
